// File: rtl/mock_mem_pipe.sv
// mock_mem_pipe: byte-addressable mock memory with valid/ready request and
// response channels, per-byte write strobes, a RD_LATENCY-deep read pipeline
// that freezes under response backpressure, and out-of-range error reporting.
// Optional build macro MOCK_MEM_STATS_EN adds saturating 32-bit counters of
// accepted reads, accepted writes and out-of-range requests.
module mock_mem_pipe #(
    parameter int unsigned           MEM_BYTES   = 4096,
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 64,
    parameter logic [ADDR_WIDTH-1:0] ADDR_OFFSET = 'h41FFF000,
    parameter int unsigned           RD_LATENCY  = 2,
    parameter logic [7:0]            INIT_BYTE   = 8'hFF,
    localparam int unsigned          DW_B        = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DW_B-1:0]       req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
`ifdef MOCK_MEM_STATS_EN
    ,
    output logic [31:0]           stat_rd_cnt,
    output logic [31:0]           stat_wr_cnt,
    output logic [31:0]           stat_err_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(MEM_BYTES);
    // Highest base whose whole beat still fits; comparing against it avoids
    // the overflow that base + DW_B could hit near the top of the address map.
    localparam logic [ADDR_WIDTH-1:0] LAST_BASE = ADDR_WIDTH'(MEM_BYTES - DW_B);

    // Contents live only in the declaration initializer so reset never clears them.
    logic [7:0] mem [MEM_BYTES] = '{default: INIT_BYTE};

    logic                  st_valid [RD_LATENCY];
    logic [DATA_WIDTH-1:0] st_data  [RD_LATENCY];
    logic                  st_err   [RD_LATENCY];

    logic [ADDR_WIDTH-1:0] base;
    logic                  oor;
    logic                  stall;
    logic                  acc;
    logic                  rd_acc;
    logic                  wr_acc;
    logic [DATA_WIDTH-1:0] rd_data;

    assign base      = req_addr - ADDR_OFFSET;
    assign oor       = base > LAST_BASE;
    assign stall     = rsp_valid & ~rsp_ready;
    assign req_ready = ~stall;
    assign acc       = req_valid & req_ready;
    assign rd_acc    = acc & ~req_we;
    assign wr_acc    = acc & req_we & ~oor;

    assign rsp_valid = st_valid[RD_LATENCY-1];
    assign rsp_rdata = st_data[RD_LATENCY-1];
    assign rsp_err   = st_err[RD_LATENCY-1];

    // Gather the beat's bytes from storage; out-of-range reads return zero.
    always_comb begin
        rd_data = '0;
        if (!oor) begin
            for (int j = 0; j < int'(DW_B); j++) begin
                rd_data[8*j +: 8] = mem[base[IDX_W-1:0] + IDX_W'(j)];
            end
        end
    end

    // Commit strobed bytes of an in-range write; out-of-range writes are dropped whole.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int j = 0; j < int'(DW_B); j++) begin
                if (req_be[j]) begin
                    mem[base[IDX_W-1:0] + IDX_W'(j)] <= req_wdata[8*j +: 8];
                end
            end
        end
    end

    // Read pipeline: every stage advances together unless the final response is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                st_valid[i] <= 1'b0;
                st_data[i]  <= '0;
                st_err[i]   <= 1'b0;
            end
        end else if (!stall) begin
            st_valid[0] <= rd_acc;
            st_data[0]  <= rd_acc ? rd_data : '0;
            st_err[0]   <= rd_acc & oor;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                st_valid[i] <= st_valid[i-1];
                st_data[i]  <= st_data[i-1];
                st_err[i]   <= st_err[i-1];
            end
        end
    end

`ifdef MOCK_MEM_STATS_EN
    // Saturating activity counters; a write with no strobes is not an error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_rd_cnt  <= '0;
            stat_wr_cnt  <= '0;
            stat_err_cnt <= '0;
        end else if (acc) begin
            if (!req_we && stat_rd_cnt != '1) stat_rd_cnt <= stat_rd_cnt + 32'd1;
            if (req_we && stat_wr_cnt != '1) stat_wr_cnt <= stat_wr_cnt + 32'd1;
            if (oor && !(req_we && req_be == '0) && stat_err_cnt != '1)
                stat_err_cnt <= stat_err_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mock_mem_pipe.sv
// Testbench for mock_mem_pipe: directed scenarios followed by randomized
// traffic, all checked against a byte-array memory model plus a queue of
// pending responses that each carry an age in unstalled cycles.
module tb_mock_mem_pipe;

    localparam int          L   = 2;
    localparam int          MB  = 4096;
    localparam logic [31:0] OFS = 32'h41FFF000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
`ifdef MOCK_MEM_STATS_EN
    logic [31:0] stat_rd_cnt, stat_wr_cnt, stat_err_cnt;
`endif

    always #5 clk = ~clk;

    mock_mem_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
`ifdef MOCK_MEM_STATS_EN
        ,
        .stat_rd_cnt  (stat_rd_cnt),
        .stat_wr_cnt  (stat_wr_cnt),
        .stat_err_cnt (stat_err_cnt)
`endif
    );

    typedef struct {
        logic [63:0] d;
        logic        e;
        int          age;
    } rsp_t;

    int          nchecks = 0;
    int          nerr = 0;
    logic [7:0]  mm [MB];
    rsp_t        q[$];
    logic [63:0] seen[$];
    logic        last_ready;
    int unsigned m_rd = 0, m_wr = 0, m_er = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic is_oor(input logic [31:0] a);
        logic [31:0] b;
        b = a - OFS;
        return (64'(b) + 64'd8) > 64'(MB);
    endfunction

    // One clock cycle: drive at the falling edge, check, advance the model, pass the rising edge.
    task automatic step(input logic v, input logic we, input logic [31:0] a,
                        input logic [63:0] wd, input logic [7:0] be, input logic rr,
                        output logic acc);
        logic        ev, er, oo;
        logic [31:0] b;
        rsp_t        n;
        req_valid = v; req_we = we; req_addr = a; req_wdata = wd; req_be = be; rsp_ready = rr;
        #1;
        ev = (q.size() > 0) && (q[0].age == L - 1);
        er = !(ev && !rr);
        last_ready = req_ready;
        check("rsp_valid", 64'(rsp_valid), 64'(ev));
        check("req_ready", 64'(req_ready), 64'(er));
        if (ev) begin
            check("rsp_rdata", rsp_rdata, q[0].d);
            check("rsp_err", 64'(rsp_err), 64'(q[0].e));
            if (rr) seen.push_back(rsp_rdata);
        end
        acc = v && er;
        b   = a - OFS;
        oo  = is_oor(a);
        if (er) begin
            if (ev) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (acc && !we) begin
                n.e = oo;
                n.d = '0;
                n.age = 0;
                if (!oo) for (int j = 0; j < 8; j++) n.d[8*j +: 8] = mm[int'(b) + j];
                q.push_back(n);
            end
            if (acc && we && !oo)
                for (int j = 0; j < 8; j++) if (be[j]) mm[int'(b) + j] = wd[8*j +: 8];
        end
        if (acc) begin
            if (we) m_wr++; else m_rd++;
            if (oo && !(we && be == 8'h00)) m_er++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rr);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, rr, acc);
    endtask

    // Assert reset asynchronously mid-cycle and hold it across one rising edge.
    task automatic reset_pulse();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        q.delete();
        m_rd = 0; m_wr = 0; m_er = 0;
        @(posedge clk);
        #1;
`ifdef MOCK_MEM_STATS_EN
        check("rst_stat_rd", 64'(stat_rd_cnt), 64'd0);
        check("rst_stat_wr", 64'(stat_wr_cnt), 64'd0);
        check("rst_stat_err", 64'(stat_err_cnt), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic        acc;
        logic [31:0] a;
        int          r;
        for (int i = 0; i < MB; i++) mm[i] = 8'hFF;

        @(negedge clk);
        reset_pulse();

        // Full-beat write then read back.
        seen.delete();
        step(1'b1, 1'b1, OFS, 64'h0102030405060708, 8'hFF, 1'b1, acc);
        step(1'b1, 1'b0, OFS, '0, '0, 1'b1, acc);
        idle(3, 1'b1);
        check("t1_count", 64'(seen.size()), 64'd1);
        if (seen.size() > 0) check("t1_data", seen[0], 64'h0102030405060708);

        // Partial strobe write leaves upper bytes at their initial value.
        seen.delete();
        step(1'b1, 1'b1, OFS + 32'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b1, acc);
        step(1'b1, 1'b0, OFS + 32'h10, '0, '0, 1'b1, acc);
        idle(3, 1'b1);
        check("t2_count", 64'(seen.size()), 64'd1);
        if (seen.size() > 0) check("t2_data", seen[0], 64'hFFFFFFFFAAAAAAAA);

        // Back-to-back reads under four cycles of response backpressure.
        seen.delete();
        step(1'b1, 1'b0, OFS, '0, '0, 1'b0, acc);
        step(1'b1, 1'b0, OFS + 32'h8, '0, '0, 1'b0, acc);
        step(1'b1, 1'b0, OFS + 32'h10, '0, '0, 1'b0, acc);
        check("bp_ready_low", 64'(last_ready), 64'd0);
        step(1'b1, 1'b0, OFS + 32'h10, '0, '0, 1'b0, acc);
        step(1'b1, 1'b0, OFS + 32'h10, '0, '0, 1'b1, acc);
        check("bp_ready_high", 64'(last_ready), 64'd1);
        idle(4, 1'b1);
        check("bp_count", 64'(seen.size()), 64'd3);
        if (seen.size() == 3) begin
            check("bp_first", seen[0], 64'h0102030405060708);
            check("bp_second", seen[1], 64'hFFFFFFFFFFFFFFFF);
            check("bp_third", seen[2], 64'hFFFFFFFFAAAAAAAA);
        end

        // Out-of-range reads and a dropped out-of-range write.
        seen.delete();
        step(1'b1, 1'b0, 32'h41FFFFFC, '0, '0, 1'b1, acc);
        step(1'b1, 1'b0, 32'h41FFEFF8, '0, '0, 1'b1, acc);
        step(1'b1, 1'b1, 32'h41FFFFFC, 64'h1111111111111111, 8'hFF, 1'b1, acc);
        step(1'b1, 1'b0, 32'h41FFFFF8, '0, '0, 1'b1, acc);
        idle(3, 1'b1);
        check("oor_count", 64'(seen.size()), 64'd3);
        if (seen.size() == 3) begin
            check("oor_end", seen[0], 64'd0);
            check("oor_below", seen[1], 64'd0);
            check("oor_wr_dropped", seen[2], 64'hFFFFFFFFFFFFFFFF);
        end

        // Reset while a read response is being presented.
        step(1'b1, 1'b0, OFS, '0, '0, 1'b0, acc);
        idle(1, 1'b0);
        check("pre_rst_valid", 64'(rsp_valid), 64'd1);
        reset_pulse();
        idle(4, 1'b1);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0:       a = OFS - 32'($urandom_range(1, 64));
                1:       a = OFS + 32'(MB) - 32'($urandom_range(0, 12));
                2:       a = $urandom;
                default: a = OFS + 32'($urandom_range(0, 255));
            endcase
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
                 {$urandom, $urandom}, 8'($urandom), 1'($urandom_range(0, 3) != 0), acc);
        end

        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1, 1'b1);
        check("drain", 64'(q.size()), 64'd0);
`ifdef MOCK_MEM_STATS_EN
        check("stat_rd", 64'(stat_rd_cnt), 64'(m_rd));
        check("stat_wr", 64'(stat_wr_cnt), 64'(m_wr));
        check("stat_err", 64'(stat_err_cnt), 64'(m_er));
        reset_pulse();
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/mock_mem_pipe.md
Name: mock_mem_pipe

Overview:
- Byte-addressable simulation/FPGA mock memory for the vector accelerator's load/store path.
- Successor to the single-cycle mock memory. Adds:
  - valid/ready request and response channels
  - per-byte write strobes
  - parametrised read latency with backpressure
  - out-of-range error reporting
- Sits between the vector load/store unit and nothing else; it is the backing store in unit and system benches.

Parameters:
- MEM_BYTES, 4096: storage size in bytes.
- ADDR_WIDTH, 32: request address width (byte address).
- DATA_WIDTH, 64: data beat width; multiple of 8. DW_B = DATA_WIDTH/8.
- ADDR_OFFSET, 'h41FFF000: address mapped to byte 0 of storage.
- RD_LATENCY, 2: cycles from read accept to rsp_valid with no backpressure; must be >= 1.
- INIT_BYTE, 'hFF: value of every storage byte at time zero.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted this cycle when req_valid & req_ready.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  byte address of the beat's lowest byte.
- req_wdata  input  DATA_WIDTH  write data; byte j maps to address req_addr+j.
- req_be  input  DW_B  write byte enables; ignored for reads.
- rsp_valid  output  1  read response present.
- rsp_ready  input  1  consumer takes the response when rsp_valid & rsp_ready.
- rsp_rdata  output  DATA_WIDTH  read data; byte j = mem[base+j].
- rsp_err  output  1  the read was out of range.

Behaviour:
- base = req_addr - ADDR_OFFSET, computed modulo 2^ADDR_WIDTH. An address below ADDR_OFFSET therefore wraps large and counts as out of range.
- Beat out of range when base + DW_B > MEM_BYTES, evaluated without overflow. Misaligned beats inside range are legal.
- Read pipeline:
  - RD_LATENCY stages, each a valid bit, data and err. The final stage drives rsp_valid, rsp_rdata and rsp_err.
  - stall = rsp_valid & ~rsp_ready. When not stalled, every stage shifts forward one position. Stage 0 loads the accepted read, or a bubble if none is accepted.
  - req_ready = ~stall, combinational from rsp_ready. This applies to reads and writes alike; nothing is accepted during a stall.
- Read data is sampled from storage at the accept edge. If out of range: data = 0 and err = 1.
- Writes:
  - On the accept edge, each byte j with req_be[j]=1 is written to mem[base+j].
  - An out-of-range write is dropped entirely, with no partial bytes written, and produces no response.
  - Writes never produce a response.
- Ordering: one request per cycle. A read accepted in cycle N+1 observes a write accepted in cycle N.
- Latency:
  - Read accepted at edge N gives rsp_valid high after edge N+RD_LATENCY-1, i.e. visible in cycle N+RD_LATENCY, when unstalled.
  - Full throughput is one read per cycle.
- Responses return in request order. No reordering and no response is dropped.
- Reset, asynchronous:
  - rsp_valid=0, rsp_rdata=0, rsp_err=0; all stage valid bits cleared.
  - req_ready is 1 after reset because rsp_valid=0.
  - Storage is not cleared. It holds INIT_BYTE only at time zero and keeps written contents across reset.
- Reset mid-operation: in-flight reads are discarded. A write accepted on an edge before reset assertion stays committed.
- req_be = 0 on a write: accepted, no storage change, no error even if out of range.

Optional Feature:
- Macro MOCK_MEM_STATS_EN.
- Defined:
  - Adds outputs stat_rd_cnt, stat_wr_cnt, stat_err_cnt, each 32 bits.
  - These are saturating counters of accepted reads, accepted writes, and out-of-range requests (read or write).
  - They increment on the accept edge and reset to 0 on rst.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Write 'h0102030405060708 to 'h41FFF000 with be='hFF, then read 'h41FFF000 with rsp_ready=1 -> rsp_valid appears 2 cycles after accept with rdata='h0102030405060708, err=0.
- Write 'hAAAAAAAAAAAAAAAA to 'h41FFF010 with be='h0F, then read -> rdata='hFFFFFFFFAAAAAAAA.
- Issue back-to-back reads to 'h41FFF000, 'h41FFF008 and 'h41FFF010 with rsp_ready held 0 for 4 cycles -> req_ready drops once the first response is presented. All three responses then arrive in order, one per cycle, after rsp_ready rises; none are lost or duplicated.
- Read 'h41FFFFFC (crosses the end), then read 'h41FFEFF8 (below the offset) -> both return rdata=0, err=1. Write 'h1111111111111111 to 'h41FFFFFC -> storage bytes FFC..FFF stay 'hFF.
- Accept a read, then assert rst for 1 cycle before the response -> rsp_valid=0 immediately. No stale response after reset; req_ready=1.
- With MOCK_MEM_STATS_EN: 3 reads, 2 writes and 1 out-of-range read -> stat_rd_cnt=4, stat_wr_cnt=2, stat_err_cnt=1. rst clears all three to 0.
